// File: rtl/stat_read_agent_pkg.sv
// Shared widths, read latency and FSM state encoding for the statistics read agent.
package stat_read_pkg;

  localparam int unsigned STAT_ADDR_W = 10;
  localparam int unsigned STAT_DATA_W = 64;
  localparam int unsigned STAT_RD_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CAP   = 3'd3,
    ST_SOUT  = 3'd4
  } stat_state_e;

endpackage

// File: rtl/stat_read_agent_if.sv
// Bundle of host, sweep-stream and memory read-port signals around stat_read_agent.
interface stat_read_agent_if;
  import stat_read_pkg::*;

  logic                   qHostReq;
  logic [STAT_ADDR_W-1:0] qvHostIdx;
  logic                   qHostAck;
  logic [STAT_DATA_W-1:0] qvHostData;
  logic                   qSweepStart;
  logic                   qSweepBusy;
  logic                   qSweepVal;
  logic                   qSweepRdy;
  logic [STAT_ADDR_W-1:0] qvSweepIdx;
  logic [STAT_DATA_W-1:0] qvSweepData;
  logic                   qSweepLast;
  logic                   qStatREn;
  logic [STAT_ADDR_W-1:0] qvStatRAddr;
  logic [STAT_DATA_W-1:0] qvStatRData;

  modport master (
    input  qHostReq, qvHostIdx, qSweepStart, qSweepRdy, qvStatRData,
    output qHostAck, qvHostData, qSweepBusy, qSweepVal, qvSweepIdx,
           qvSweepData, qSweepLast, qStatREn, qvStatRAddr
  );

  modport slave (
    output qHostReq, qvHostIdx, qSweepStart, qSweepRdy, qvStatRData,
    input  qHostAck, qvHostData, qSweepBusy, qSweepVal, qvSweepIdx,
           qvSweepData, qSweepLast, qStatREn, qvStatRAddr
  );

endinterface

// File: rtl/stat_read_agent_sweep_ctrl.sv
// Sweep engine: element index counter, last-element detect and the valid/ready output register.
module stat_sweep_ctrl
  import stat_read_pkg::*;
#(
  parameter int unsigned STAT_CNT = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_rdy,
  input  logic                   i_load,
  input  logic [STAT_DATA_W-1:0] i_data,
  output logic                   o_busy,
  output logic                   o_fetch,
  output logic [STAT_ADDR_W-1:0] o_fetch_idx,
  output logic                   o_xfer,
  output logic                   o_val,
  output logic [STAT_ADDR_W-1:0] o_idx,
  output logic [STAT_DATA_W-1:0] o_data,
  output logic                   o_last
);

  localparam logic [STAT_ADDR_W-1:0] LP_LAST = STAT_ADDR_W'(STAT_CNT - 1);

  logic                   r_busy;
  logic [STAT_ADDR_W-1:0] r_cnt;
  logic                   r_val;
  logic [STAT_ADDR_W-1:0] r_idx;
  logic [STAT_DATA_W-1:0] r_data;
  logic                   r_last;
  logic                   w_xfer;

  assign w_xfer      = r_val & i_rdy;
  // Only one element is ever in flight, so a new fetch is wanted whenever nothing is held.
  assign o_fetch     = r_busy & ~r_val;
  assign o_fetch_idx = r_cnt;
  assign o_xfer      = w_xfer;
  assign o_busy      = r_busy;
  assign o_val       = r_val;
  assign o_idx       = r_idx;
  assign o_data      = r_data;
  assign o_last      = r_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_val  <= 1'b0;
      r_idx  <= '0;
      r_data <= '0;
      r_last <= 1'b0;
    end else begin
      if (i_start && !r_busy) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
      end
      if (i_load) begin
        r_val  <= 1'b1;
        r_idx  <= r_cnt;
        r_data <= i_data;
        r_last <= (r_cnt == LP_LAST);
      end
      if (w_xfer) begin
        r_val  <= 1'b0;
        r_last <= 1'b0;
        r_cnt  <= r_cnt + 1'b1;
        if (r_last) begin
          r_busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/stat_read_agent.sv
// Read agent for the statistics memory: host single reads plus an optional table sweep.
// Sweep engine is built only when STAT_SWEEP_EN is defined; otherwise sweep outputs are tied 0.
module stat_read_agent
  import stat_read_pkg::*;
#(
  parameter int unsigned STAT_CNT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  stat_read_agent_if.master bus
);

  localparam logic [STAT_ADDR_W:0] LP_CNT = (STAT_ADDR_W + 1)'(STAT_CNT);

  stat_state_e            r_state;
  logic                   r_ren;
  logic [STAT_ADDR_W-1:0] r_raddr;
  logic                   r_ack;
  logic [STAT_DATA_W-1:0] r_hdata;
  logic                   w_host_oor;

  assign w_host_oor      = ({1'b0, bus.qvHostIdx} >= LP_CNT);
  assign bus.qStatREn    = r_ren;
  assign bus.qvStatRAddr = r_raddr;
  assign bus.qHostAck    = r_ack;
  assign bus.qvHostData  = r_hdata;

`ifdef STAT_SWEEP_EN
  logic                   r_for_sweep;
  logic                   w_sw_fetch;
  logic                   w_sw_xfer;
  logic                   w_sw_load;
  logic [STAT_ADDR_W-1:0] w_sw_idx;

  assign w_sw_load = (r_state == ST_CAP) && r_for_sweep;

  stat_sweep_ctrl #(.STAT_CNT(STAT_CNT)) u_sweep (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (bus.qSweepStart),
    .i_rdy       (bus.qSweepRdy),
    .i_load      (w_sw_load),
    .i_data      (bus.qvStatRData),
    .o_busy      (bus.qSweepBusy),
    .o_fetch     (w_sw_fetch),
    .o_fetch_idx (w_sw_idx),
    .o_xfer      (w_sw_xfer),
    .o_val       (bus.qSweepVal),
    .o_idx       (bus.qvSweepIdx),
    .o_data      (bus.qvSweepData),
    .o_last      (bus.qSweepLast)
  );
`else
  logic w_unused;

  assign w_unused        = ^{bus.qSweepStart, bus.qSweepRdy};
  assign bus.qSweepBusy  = 1'b0;
  assign bus.qSweepVal   = 1'b0;
  assign bus.qvSweepIdx  = '0;
  assign bus.qvSweepData = '0;
  assign bus.qSweepLast  = 1'b0;
`endif

  // Fixed ISSUE -> WAIT -> CAP walk matches the STAT_RD_LAT=2 memory and spaces reads by >= 4 cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_ren   <= 1'b0;
      r_raddr <= '0;
      r_ack   <= 1'b0;
      r_hdata <= '0;
`ifdef STAT_SWEEP_EN
      r_for_sweep <= 1'b0;
`endif
    end else begin
      r_ren <= 1'b0;
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.qHostReq) begin
            if (w_host_oor) begin
              r_ack   <= 1'b1;
              r_hdata <= '0;
            end else begin
              r_state <= ST_ISSUE;
              r_ren   <= 1'b1;
              r_raddr <= bus.qvHostIdx;
`ifdef STAT_SWEEP_EN
              r_for_sweep <= 1'b0;
`endif
            end
          end
`ifdef STAT_SWEEP_EN
          else if (w_sw_fetch) begin
            r_state     <= ST_ISSUE;
            r_ren       <= 1'b1;
            r_raddr     <= w_sw_idx;
            r_for_sweep <= 1'b1;
          end
`endif
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT:  r_state <= ST_CAP;
        ST_CAP: begin
`ifdef STAT_SWEEP_EN
          if (r_for_sweep) begin
            r_state <= ST_SOUT;
          end else begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b1;
            r_hdata <= bus.qvStatRData;
          end
`else
          r_state <= ST_IDLE;
          r_ack   <= 1'b1;
          r_hdata <= bus.qvStatRData;
`endif
        end
`ifdef STAT_SWEEP_EN
        ST_SOUT: begin
          if (w_sw_xfer) begin
            r_state <= ST_IDLE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stat_read_agent.sv
// Randomised bench for stat_read_agent against a behavioural memory/host/sweep model (STAT_CNT=8).
module tb_stat_read_agent;
  import stat_read_pkg::*;

  localparam int unsigned CNT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stat_read_agent_if bif ();

  stat_read_agent #(.STAT_CNT(CNT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bif)
  );

  logic [63:0] mem [0:1023];
  logic        p1_v;
  logic [63:0] p1_d;

  // Two-cycle memory; outside the valid cycle the read bus carries junk.
  always @(posedge clk) begin
    p1_v <= bif.qStatREn;
    p1_d <= mem[bif.qvStatRAddr];
    bif.qvStatRData <= p1_v ? p1_d : {$urandom, $urandom};
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] host_model(input logic [9:0] idx);
    return ({22'd0, idx} < CNT) ? mem[idx] : 64'd0;
  endfunction

  logic [9:0]  cur_idx = '0;
  logic [63:0] last_hdata = '0;
  logic        prev_ren = 1'b0, prev_val = 1'b0, prev_rdy = 1'b0;
  int          ren_cnt = 0;
  bit          m_busy = 0;
  int          exp_idx = 0;
  int          beats = 0;
  int          lasts = 0;
  bit          rdy_rand = 0;
  logic        rdy_fix = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outs", 64'({bif.qHostAck, bif.qStatREn, bif.qvStatRAddr, bif.qSweepVal,
                             bif.qSweepBusy, bif.qSweepLast, bif.qvSweepIdx}), 64'd0);
      chk("reset_hdata", bif.qvHostData, 64'd0);
      chk("reset_sdata", bif.qvSweepData, 64'd0);
      last_hdata = '0;
      m_busy = 0;
      exp_idx = 0;
    end else begin
      if (bif.qStatREn) begin
        ren_cnt++;
        chk("ren_spacing", 64'(prev_ren), 64'd0);
        chk("ren_addr_range", 64'({22'd0, bif.qvStatRAddr} < CNT), 64'd1);
      end
      if (bif.qHostAck) begin
        chk("ack_data", bif.qvHostData, host_model(cur_idx));
        last_hdata = bif.qvHostData;
      end else begin
        chk("hdata_hold", bif.qvHostData, last_hdata);
      end
`ifdef STAT_SWEEP_EN
      chk("sweep_busy", 64'(bif.qSweepBusy), 64'(m_busy));
      if (prev_val && !prev_rdy) chk("sweep_val_hold", 64'(bif.qSweepVal), 64'd1);
      if (bif.qSweepVal) begin
        chk("sweep_idx", 64'(bif.qvSweepIdx), 64'(exp_idx));
        chk("sweep_data", bif.qvSweepData, mem[exp_idx]);
        chk("sweep_last", 64'(bif.qSweepLast), 64'(exp_idx == int'(CNT) - 1));
      end else begin
        chk("sweep_last_idle", 64'(bif.qSweepLast), 64'd0);
      end
      begin
        bit st;
        st = bif.qSweepStart && !m_busy;
        if (bif.qSweepVal && bif.qSweepRdy) begin
          beats++;
          if (exp_idx == int'(CNT) - 1) begin
            lasts++;
            m_busy = 0;
          end
          exp_idx++;
        end
        if (st) begin
          m_busy = 1;
          exp_idx = 0;
        end
      end
`else
      chk("sweep_tied", 64'({bif.qSweepVal, bif.qSweepBusy, bif.qSweepLast, bif.qvSweepIdx}), 64'd0);
      chk("sweep_data_tied", bif.qvSweepData, 64'd0);
`endif
    end
    prev_ren = bif.qStatREn;
    prev_val = bif.qSweepVal;
    prev_rdy = bif.qSweepRdy;
  end

  initial begin
    bif.qSweepRdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bif.qSweepRdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_read(input logic [9:0] idx, input int exp_lat, output logic [63:0] data);
    int   lat;
    bit   got;
    logic ren1;
    logic [9:0] a1;
    @(posedge clk);
    #1;
    cur_idx = idx;
    bif.qvHostIdx = idx;
    bif.qHostReq = 1'b1;
    got = 0;
    lat = 0;
    ren1 = 1'b0;
    a1 = '0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        ren1 = bif.qStatREn;
        a1 = bif.qvStatRAddr;
      end
      if (bif.qHostAck) got = 1;
    end
    bif.qHostReq = 1'b0;
    data = bif.qvHostData;
    chk("host_ack_timeout", 64'(got), 64'd1);
    if (exp_lat > 0) begin
      chk("host_latency", 64'(lat), 64'(exp_lat));
      chk("host_ren_n1", 64'(ren1), 64'(exp_lat == 4));
      if (exp_lat == 4) chk("host_addr", 64'(a1), 64'(idx));
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    bif.qSweepStart = 1'b1;
    @(posedge clk);
    #1;
    bif.qSweepStart = 1'b0;
  endtask

`ifdef STAT_SWEEP_EN
  task automatic wait_sweep_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (!bif.qSweepBusy) ok = 1;
    end
  endtask

  task automatic wait_sweep_idx(input int k, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (bif.qSweepVal && int'(bif.qvSweepIdx) == k) ok = 1;
    end
  endtask
`endif

  initial begin
    logic [63:0] d;
    int          r0, t_prev, nack;
    int          t_ack [3];
    bit          got;
    bit          ok;
    int          b0, l0;
    logic [9:0]  ridx;

    bif.qHostReq = 1'b0;
    bif.qvHostIdx = '0;
    bif.qSweepStart = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    mem[5] = 64'h1234;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 64'(bif.qHostAck), 64'd0);
    chk("reset_ren", 64'(bif.qStatREn), 64'd0);
    rst = 1'b0;
    idle(2);

    // Directed single read: REn at N+1, ack at N+4 with the memory word.
    host_read(10'd5, 4, d);
    chk("t1_data", d, 64'h1234);
    idle(2);

    // Request held high across acks: three back-to-back re-reads.
    r0 = ren_cnt;
    @(posedge clk);
    #1;
    cur_idx = 10'd3;
    bif.qvHostIdx = 10'd3;
    bif.qHostReq = 1'b1;
    nack = 0;
    t_prev = 0;
    got = 0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(posedge clk);
      #1;
      if (bif.qHostAck) begin
        t_ack[nack] = c;
        nack++;
        if (nack == 3) begin
          bif.qHostReq = 1'b0;
          got = 1;
        end
      end
    end
    chk("t2_timeout", 64'(got), 64'd1);
    chk("t2_first_ack", 64'(t_ack[0]), 64'd4);
    chk("t2_gap1", 64'(t_ack[1] - t_ack[0]), 64'd4);
    chk("t2_gap2", 64'(t_ack[2] - t_ack[1]), 64'd4);
    idle(6);
    chk("t2_ren_count", 64'(ren_cnt - r0), 64'd3);

    // Out-of-range indices: ack next cycle, zero data, no memory access.
    r0 = ren_cnt;
    host_read(10'd20, 1, d);
    chk("t3_oor20", d, 64'd0);
    host_read(10'd8, 1, d);
    chk("t3_oor8", d, 64'd0);
    host_read(10'd1023, 1, d);
    chk("t3_oor1023", d, 64'd0);
    idle(3);
    chk("t3_no_ren", 64'(ren_cnt - r0), 64'd0);
    host_read(10'd7, 4, d);
    chk("t3_last_in_range", d, mem[7]);

    for (int k = 0; k < 30; k++) begin
      ridx = 10'($urandom_range(0, 15));
      host_read(ridx, ({22'd0, ridx} < CNT) ? 4 : 1, d);
      chk("rand_host_data", d, host_model(ridx));
      idle($urandom_range(0, 3));
    end

`ifdef STAT_SWEEP_EN
    // Full sweep with random ready; a second start mid-sweep must be ignored.
    rdy_rand = 1;
    b0 = beats;
    l0 = lasts;
    pulse_start();
    idle(10);
    pulse_start();
    wait_sweep_idle(ok);
    chk("t4_timeout", 64'(ok), 64'd1);
    chk("t4_beats", 64'(beats - b0), 64'(CNT));
    chk("t4_last_once", 64'(lasts - l0), 64'd1);
    idle(3);

    // Host read interleaved at sweep element 3.
    b0 = beats;
    pulse_start();
    wait_sweep_idx(3, ok);
    chk("t5_reach3", 64'(ok), 64'd1);
    host_read(10'd6, 0, d);
    chk("t5_host_data", d, mem[6]);
    wait_sweep_idle(ok);
    chk("t5_timeout", 64'(ok), 64'd1);
    chk("t5_beats", 64'(beats - b0), 64'(CNT));
    idle(3);

    // Asynchronous reset while element 2 is being offered.
    pulse_start();
    wait_sweep_idx(2, ok);
    chk("t6_reach2", 64'(ok), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_val", 64'(bif.qSweepVal), 64'd0);
    chk("t6_busy", 64'(bif.qSweepBusy), 64'd0);
    chk("t6_idx", 64'(bif.qvSweepIdx), 64'd0);
    chk("t6_data", bif.qvSweepData, 64'd0);
    chk("t6_ren", 64'(bif.qStatREn), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    r0 = ren_cnt;
    idle(20);
    chk("t6_no_ren", 64'(ren_cnt - r0), 64'd0);
    chk("t6_busy_after", 64'(bif.qSweepBusy), 64'd0);
    rdy_rand = 0;
    host_read(10'd2, 4, d);
    chk("t6_host_after", d, mem[2]);
`else
    // Without the sweep engine, start and ready do nothing.
    r0 = ren_cnt;
    rdy_rand = 1;
    pulse_start();
    idle(20);
    chk("nosweep_no_ren", 64'(ren_cnt - r0), 64'd0);
    chk("nosweep_busy", 64'(bif.qSweepBusy), 64'd0);
`endif

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
